// File: rtl/datamemory_pkg.sv
// Shared constants and encodings for the data memory block.
// Holds the default depth/width and the RV32I load/store funct3 encodings
// used by the top level and the load formatter.
package datamemory_pkg;

    // Default memory depth in bytes (must be a power of two).
    localparam int MEM_SIZE_DEF         = 256;
    // Default data word width in bits.
    localparam int INSTRUCTION_SIZE_DEF = 32;

    // RV32I access size / signedness encodings carried on funct3.
    typedef enum logic [2:0] {
        F3_B  = 3'b000,   // signed byte
        F3_H  = 3'b001,   // signed halfword
        F3_W  = 3'b010,   // word
        F3_BU = 3'b100,   // unsigned byte
        F3_HU = 3'b101    // unsigned halfword
    } funct3_e;

    // True for the three store encodings that actually write memory.
    function automatic logic is_store_f3(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage

// File: rtl/datamemory_load_formatter.sv
// Load formatter: turns the raw little-endian word read at the access
// address into read_data, applying size selection and sign/zero extension.
// Ports: mem_read gates the output, funct3 selects size/sign, raw_word is
// the bytes at address..address+3, read_data is the result. Purely combinational.
module load_formatter
    import datamemory_pkg::*;
#(
    parameter int INSTRUCTION_SIZE = INSTRUCTION_SIZE_DEF
) (
    input  logic                        mem_read,
    input  logic [2:0]                  funct3,
    input  logic [INSTRUCTION_SIZE-1:0] raw_word,
    output logic [INSTRUCTION_SIZE-1:0] read_data
);

    always_comb begin
        read_data = '0;
        if (mem_read) begin
            case (funct3)
                F3_B:  read_data = {{(INSTRUCTION_SIZE-8){raw_word[7]}},   raw_word[7:0]};
                F3_H:  read_data = {{(INSTRUCTION_SIZE-16){raw_word[15]}}, raw_word[15:0]};
                F3_W:  read_data = raw_word;
                F3_BU: read_data = {{(INSTRUCTION_SIZE-8){1'b0}},  raw_word[7:0]};
                F3_HU: read_data = {{(INSTRUCTION_SIZE-16){1'b0}}, raw_word[15:0]};
                // Reserved encodings read as zero rather than garbage.
                default: read_data = '0;
            endcase
        end
    end

endmodule

// File: rtl/datamemory.sv
// Byte-addressed little-endian data memory for an RV32I core.
// Ports: clk/reset (sync, active-high), mem_read/mem_write enables, byte
// address, write_data, funct3 size/sign; read_data is combinational.
module datamemory
    import datamemory_pkg::*;
#(
    parameter int MEM_SIZE         = MEM_SIZE_DEF,
    parameter int INSTRUCTION_SIZE = INSTRUCTION_SIZE_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [$clog2(MEM_SIZE)-1:0] address,
    input  logic [INSTRUCTION_SIZE-1:0] write_data,
    input  logic [2:0]                  funct3,
    output logic [INSTRUCTION_SIZE-1:0] read_data
);

    localparam int AW = $clog2(MEM_SIZE);
    localparam int NB = INSTRUCTION_SIZE / 8;   // bytes per word

    logic [7:0]                  mem [MEM_SIZE];
    logic [AW-1:0]               lane_addr [NB];
    logic [NB-1:0]               lane_we;
    logic [INSTRUCTION_SIZE-1:0] raw_word;

    // Lane k of an access lives at address+k; the truncation to AW bits
    // gives the modulo-MEM_SIZE wrap for free. Lanes are distinct as long
    // as MEM_SIZE >= NB, so misaligned and wrapping accesses need no
    // special handling.
    for (genvar k = 0; k < NB; k++) begin : g_lane
        assign lane_addr[k]        = address + AW'(k);
        assign raw_word[8*k +: 8]  = mem[lane_addr[k]];
    end

    // Store byte-lane enables from the access size; reserved encodings
    // enable nothing so memory is left untouched.
    always_comb begin
        lane_we = '0;
        if (is_store_f3(funct3)) begin
            case (funct3)
                F3_B:    lane_we = NB'(1);
                F3_H:    lane_we = NB'(3);
                F3_W:    lane_we = '1;
                default: lane_we = '0;
            endcase
        end
    end

    // Reset wins over a coincident store: the whole array clears that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem[AW'(i)] <= 8'h00;
            end
        end else if (mem_write) begin
            for (int k = 0; k < NB; k++) begin
                if (lane_we[k]) begin
                    mem[lane_addr[k]] <= write_data[8*k +: 8];
                end
            end
        end
    end

    // Loads see the array as it stands now, so a simultaneous load/store
    // shows pre-write data until the edge.
    load_formatter #(
        .INSTRUCTION_SIZE (INSTRUCTION_SIZE)
    ) u_load_formatter (
        .mem_read  (mem_read),
        .funct3    (funct3),
        .raw_word  (raw_word),
        .read_data (read_data)
    );

endmodule

// File: tb/tb_datamemory.sv
// Self-checking bench for datamemory: directed accesses push expected load
// results into a scoreboard queue; a monitor pops and compares on the
// falling edge whenever a checked access is presented.
module tb_datamemory;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [2:0]  funct3;
    logic [31:0] read_data;

    logic        probe;
    logic [31:0] exp_q  [$];
    string       name_q [$];
    int          n_chk;
    int          n_fail;

    datamemory dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .funct3     (funct3),
        .read_data  (read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: compares mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (probe) begin
            n_chk = n_chk + 1;
            if (exp_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL scoreboard_empty: got %h with no expected value", read_data);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (read_data !== e) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: read_data=%h expected=%h", nm, read_data, e);
                end
            end
        end
    end

    // One cycle of stimulus, launched just after a rising edge.
    task automatic access(input bit rd, input bit wr, input bit chk,
                          input logic [7:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [31:0] exp,
                          input string nm);
        mem_read   = rd;
        mem_write  = wr;
        address    = a;
        funct3     = f3;
        write_data = wd;
        if (chk) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
        probe = chk;
        @(posedge clk);
        #1;
        probe     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic st(input logic [7:0] a, input logic [2:0] f3, input logic [31:0] wd);
        access(1'b0, 1'b1, 1'b0, a, f3, wd, 32'h0, "store");
    endtask

    task automatic ld(input logic [7:0] a, input logic [2:0] f3,
                      input logic [31:0] exp, input string nm);
        access(1'b1, 1'b0, 1'b1, a, f3, 32'h0, exp, nm);
    endtask

    // Reset pulse, optionally with a store attempted in the same cycle.
    task automatic pulse_reset(input bit wr, input logic [7:0] a, input logic [31:0] wd);
        reset      = 1'b1;
        mem_write  = wr;
        address    = a;
        funct3     = 3'b010;
        write_data = wd;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        probe      = 1'b0;
        reset      = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = 8'h00;
        write_data = 32'h0;
        funct3     = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        ld(8'h00, 3'b010, 32'h00000000, "reset_lw_00");
        ld(8'h7C, 3'b010, 32'h00000000, "reset_lw_7c");

        // Word store/load and sub-word reads of it
        st(8'h00, 3'b010, 32'hAABBCCDD);
        ld(8'h00, 3'b010, 32'hAABBCCDD, "sw_lw_00");
        ld(8'h03, 3'b000, 32'hFFFFFFAA, "lb_03");
        ld(8'h01, 3'b101, 32'h0000BBCC, "lhu_01");

        // Halfword
        st(8'h10, 3'b001, 32'h0000BEEF);
        ld(8'h10, 3'b001, 32'hFFFFBEEF, "lh_10");
        ld(8'h10, 3'b101, 32'h0000BEEF, "lhu_10");
        ld(8'h10, 3'b010, 32'h0000BEEF, "lw_10_after_sh");

        // Byte, neighbours untouched
        st(8'h20, 3'b000, 32'h000000AA);
        ld(8'h20, 3'b000, 32'hFFFFFFAA, "lb_20");
        ld(8'h20, 3'b100, 32'h000000AA, "lbu_20");
        ld(8'h20, 3'b010, 32'h000000AA, "lw_20");

        // Partial overwrites inside a populated word
        st(8'h30, 3'b010, 32'hFFFFFFFF);
        st(8'h31, 3'b000, 32'hFFFFFF12);
        ld(8'h30, 3'b010, 32'hFFFF12FF, "sb_into_word");
        st(8'h32, 3'b001, 32'hABCD5678);
        ld(8'h30, 3'b010, 32'h567812FF, "sh_into_word");

        // Misaligned word
        st(8'h41, 3'b010, 32'hDEADBEEF);
        ld(8'h41, 3'b010, 32'hDEADBEEF, "lw_misaligned_41");
        ld(8'h40, 3'b100, 32'h00000000, "lbu_40_untouched");
        ld(8'h44, 3'b100, 32'h000000DE, "lbu_44");
        ld(8'h45, 3'b100, 32'h00000000, "lbu_45_untouched");

        // Wrap-around at the top of memory
        st(8'hFE, 3'b010, 32'h11223344);
        ld(8'hFE, 3'b010, 32'h11223344, "lw_wrap_fe");
        ld(8'h00, 3'b100, 32'h00000022, "lbu_wrap_00");
        ld(8'h00, 3'b010, 32'hAABB1122, "lw_00_after_wrap");

        // mem_read low and reserved load encodings read zero
        access(1'b0, 1'b0, 1'b1, 8'h10, 3'b010, 32'h0, 32'h0, "no_read_zero");
        ld(8'h10, 3'b011, 32'h00000000, "load_f3_011");
        ld(8'h10, 3'b110, 32'h00000000, "load_f3_110");
        ld(8'h10, 3'b111, 32'h00000000, "load_f3_111");

        // Reserved store encodings leave memory alone
        st(8'h10, 3'b011, 32'hFFFFFFFF);
        st(8'h10, 3'b100, 32'hFFFFFFFF);
        st(8'h10, 3'b101, 32'hFFFFFFFF);
        st(8'h10, 3'b111, 32'hFFFFFFFF);
        ld(8'h10, 3'b010, 32'h0000BEEF, "reserved_store_ignored");

        // Simultaneous read/write: old data before the edge, new after
        access(1'b1, 1'b1, 1'b1, 8'h50, 3'b010, 32'h0BADF00D, 32'h00000000, "rw_pre_edge");
        ld(8'h50, 3'b010, 32'h0BADF00D, "rw_post_edge");

        // Reset with a coincident store: reset wins, everything clears
        pulse_reset(1'b1, 8'h60, 32'h12345678);
        ld(8'h60, 3'b010, 32'h00000000, "reset_beats_store");
        ld(8'h00, 3'b010, 32'h00000000, "reset_clears_00");
        ld(8'h10, 3'b010, 32'h00000000, "reset_clears_10");
        ld(8'hFE, 3'b010, 32'h00000000, "reset_clears_fe");

        @(negedge clk);
        n_chk = n_chk + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain: %0d expected values left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
